// File: rtl/wave_sample_gen.sv
// Per-channel waveform sample engine: phase accumulator advanced on each sample tick,
// producing sawtooth / triangle / square / DC DAC codes with wrap-synchronous config updates.
module wave_sample_gen #(
   parameter int PHASE_W = 16,
   parameter int DATA_W  = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               enable,
   input  logic [1:0]         wave_sel,
   input  logic [PHASE_W-1:0] freq_word,
   input  logic [DATA_W-1:0]  duty,
   input  logic [DATA_W-1:0]  dc_level,
   output logic [DATA_W-1:0]  sample,
   output logic               sample_valid,
   output logic               cycle_start
);

   typedef enum logic [1:0] {
      W_SAW = 2'd0,
      W_TRI = 2'd1,
      W_SQR = 2'd2,
      W_DC  = 2'd3
   } wave_t;

   typedef struct packed {
      wave_t              sel;
      logic [PHASE_W-1:0] fw;
      logic [DATA_W-1:0]  duty;
      logic [DATA_W-1:0]  dc;
   } cfg_t;

   cfg_t               cfg_live;
   cfg_t               cfg_sh;
   logic [PHASE_W-1:0] phase;
   logic               first_flag;
   logic [PHASE_W:0]   sum;
   logic               carry;
   logic [DATA_W-1:0]  p;
   logic [DATA_W-1:0]  p2;
   logic               m;
   logic [DATA_W-1:0]  wave_val;

   always_comb begin
      cfg_live.sel  = wave_t'(wave_sel);
      cfg_live.fw   = freq_word;
      cfg_live.duty = duty;
      cfg_live.dc   = dc_level;
   end

   assign sum   = {1'b0, phase} + {1'b0, cfg_sh.fw};
   assign carry = sum[PHASE_W];
   assign p     = phase[PHASE_W-1 -: DATA_W];
   assign p2    = phase[PHASE_W-2 -: DATA_W];
   assign m     = phase[PHASE_W-1];

   // Triangle folds the second half of the period using one extra phase bit.
   always_comb begin
      wave_val = '0;
      case (cfg_sh.sel)
         W_SAW: wave_val = p;
         W_TRI: wave_val = m ? ~p2 : p2;
         W_SQR: wave_val = (p < cfg_sh.duty) ? {DATA_W{1'b1}} : '0;
         W_DC:  wave_val = cfg_sh.dc;
         default: wave_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase        <= '0;
         sample       <= '0;
         sample_valid <= 1'b0;
         cycle_start  <= 1'b0;
         cfg_sh       <= '0;
         first_flag   <= 1'b1;
      end else if (!enable) begin
         cfg_sh       <= cfg_live;
         phase        <= '0;
         first_flag   <= 1'b1;
         sample       <= '0;
         sample_valid <= 1'b0;
         cycle_start  <= 1'b0;
      end else if (tick) begin
         sample       <= wave_val;
         phase        <= sum[PHASE_W-1:0];
         sample_valid <= 1'b1;
         cycle_start  <= first_flag;
         // Config only changes at a period boundary so the waveform never glitches.
         if (carry) begin
            cfg_sh     <= cfg_live;
            first_flag <= 1'b1;
         end else begin
            first_flag <= 1'b0;
         end
      end else begin
         sample_valid <= 1'b0;
         cycle_start  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wave_sample_gen.sv
// Directed self-checking bench for wave_sample_gen: each task drives one scenario
// and compares outputs 1 ns after the sampling clock edge.
module tb_wave_sample_gen;
   localparam int PHASE_W = 16;
   localparam int DATA_W  = 12;

   logic               clk;
   logic               rst;
   logic               tick;
   logic               enable;
   logic [1:0]         wave_sel;
   logic [PHASE_W-1:0] freq_word;
   logic [DATA_W-1:0]  duty;
   logic [DATA_W-1:0]  dc_level;
   logic [DATA_W-1:0]  sample;
   logic               sample_valid;
   logic               cycle_start;

   int checks   = 0;
   int failures = 0;

   wave_sample_gen #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .tick(tick), .enable(enable), .wave_sel(wave_sel),
      .freq_word(freq_word), .duty(duty), .dc_level(dc_level),
      .sample(sample), .sample_valid(sample_valid), .cycle_start(cycle_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All tasks start and end 1 ns after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick(input int gap);
      repeat (gap) step();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   // One idle cycle with enable low loads the shadow config and zeroes the phase.
   task automatic load_cfg(input logic [1:0] sel, input logic [PHASE_W-1:0] fw,
                           input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] dc);
      enable = 1'b0; wave_sel = sel; freq_word = fw; duty = d; dc_level = dc;
      step();
      enable = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; tick = 1'b0;
      wave_sel = 2'd0; freq_word = '0; duty = '0; dc_level = '0;
      repeat (3) step();
      checks++; if (sample !== 12'h000 || sample_valid !== 1'b0 || cycle_start !== 1'b0) begin
         failures++; $display("FAIL reset_state got s=%h v=%b c=%b exp s=000 v=0 c=0", sample, sample_valid, cycle_start); end
      rst = 1'b0;
      load_cfg(2'd0, 16'h1000, 12'h000, 12'h000);
      repeat (3) pulse_tick(1);
      checks++; if (sample !== 12'h200) begin
         failures++; $display("FAIL reset_prerun got=%h exp=200", sample); end
      // Reset asserted together with tick must win.
      rst = 1'b1; tick = 1'b1;
      step();
      checks++; if (sample !== 12'h000 || sample_valid !== 1'b0 || cycle_start !== 1'b0) begin
         failures++; $display("FAIL reset_with_tick got s=%h v=%b c=%b exp s=000 v=0 c=0", sample, sample_valid, cycle_start); end
      repeat (2) step();
      rst = 1'b0; tick = 1'b0;
      pulse_tick(1);
      checks++; if (sample !== 12'h000 || sample_valid !== 1'b1 || cycle_start !== 1'b1) begin
         failures++; $display("FAIL reset_first_sample got s=%h v=%b c=%b exp s=000 v=1 c=1", sample, sample_valid, cycle_start); end
   endtask

   // Shadow fw is 0 after reset: phase frozen, only one cycle_start.
   task automatic test_fw_zero();
      for (int i = 0; i < 4; i++) begin
         pulse_tick(2);
         checks++; if (sample !== 12'h000 || sample_valid !== 1'b1 || cycle_start !== 1'b0) begin
            failures++; $display("FAIL fw0[%0d] got s=%h v=%b c=%b exp s=000 v=1 c=0", i, sample, sample_valid, cycle_start); end
      end
   endtask

   task automatic test_sawtooth();
      logic [DATA_W-1:0] exp;
      load_cfg(2'd0, 16'h1000, 12'h000, 12'h000);
      for (int i = 0; i < 17; i++) begin
         // tick raised for one clock; result must appear exactly one clock later
         repeat (50) step();
         checks++; if (sample_valid !== 1'b0) begin
            failures++; $display("FAIL saw_idle_valid[%0d] got=%b exp=0", i, sample_valid); end
         tick = 1'b1;
         step();
         tick = 1'b0;
         exp = 12'((i % 16) << 8);
         checks++; if (sample !== exp || sample_valid !== 1'b1 || cycle_start !== (i % 16 == 0)) begin
            failures++; $display("FAIL saw[%0d] got s=%h v=%b c=%b exp s=%h v=1 c=%b", i, sample, sample_valid, cycle_start, exp, (i % 16 == 0)); end
      end
      step();
      checks++; if (sample_valid !== 1'b0 || cycle_start !== 1'b0 || sample !== 12'h000) begin
         failures++; $display("FAIL saw_hold got s=%h v=%b c=%b exp s=000 v=0 c=0", sample, sample_valid, cycle_start); end
   endtask

   task automatic test_triangle();
      logic [DATA_W-1:0] tri_tab [8];
      tri_tab = '{12'h000, 12'h400, 12'h800, 12'hC00, 12'hFFF, 12'hBFF, 12'h7FF, 12'h3FF};
      load_cfg(2'd1, 16'h2000, 12'h000, 12'h000);
      for (int i = 0; i < 16; i++) begin
         pulse_tick(2);
         checks++; if (sample !== tri_tab[i % 8] || cycle_start !== (i % 8 == 0)) begin
            failures++; $display("FAIL tri[%0d] got s=%h c=%b exp s=%h c=%b", i, sample, cycle_start, tri_tab[i % 8], (i % 8 == 0)); end
      end
   endtask

   task automatic test_square();
      logic [DATA_W-1:0] exp;
      load_cfg(2'd2, 16'h4000, 12'h800, 12'h000);
      for (int i = 0; i < 8; i++) begin
         pulse_tick(1);
         exp = ((i % 4) < 2) ? 12'hFFF : 12'h000;
         checks++; if (sample !== exp) begin
            failures++; $display("FAIL sqr_half[%0d] got=%h exp=%h", i, sample, exp); end
      end
      load_cfg(2'd2, 16'h4000, 12'h000, 12'h000);
      for (int i = 0; i < 5; i++) begin
         pulse_tick(1);
         checks++; if (sample !== 12'h000 || sample_valid !== 1'b1) begin
            failures++; $display("FAIL sqr_duty0[%0d] got s=%h v=%b exp s=000 v=1", i, sample, sample_valid); end
      end
   endtask

   task automatic test_config_wrap();
      load_cfg(2'd0, 16'h1000, 12'h000, 12'h000);
      repeat (8) pulse_tick(1);
      checks++; if (sample !== 12'h700) begin
         failures++; $display("FAIL cfg_pre got=%h exp=700", sample); end
      wave_sel = 2'd3; dc_level = 12'h5A5;
      for (int i = 8; i < 16; i++) begin
         pulse_tick(1);
         checks++; if (sample !== 12'(i << 8) || cycle_start !== 1'b0) begin
            failures++; $display("FAIL cfg_mid[%0d] got s=%h c=%b exp s=%h c=0", i, sample, cycle_start, 12'(i << 8)); end
      end
      for (int i = 0; i < 3; i++) begin
         pulse_tick(1);
         checks++; if (sample !== 12'h5A5 || cycle_start !== (i == 0)) begin
            failures++; $display("FAIL cfg_dc[%0d] got s=%h c=%b exp s=5a5 c=%b", i, sample, cycle_start, (i == 0)); end
      end
   endtask

   task automatic test_disable();
      load_cfg(2'd0, 16'h1000, 12'h000, 12'h000);
      repeat (5) pulse_tick(1);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pulse_tick(1);
         checks++; if (sample !== 12'h000 || sample_valid !== 1'b0 || cycle_start !== 1'b0) begin
            failures++; $display("FAIL dis[%0d] got s=%h v=%b c=%b exp s=000 v=0 c=0", i, sample, sample_valid, cycle_start); end
      end
      enable = 1'b1;
      pulse_tick(1);
      checks++; if (sample !== 12'h000 || cycle_start !== 1'b1 || sample_valid !== 1'b1) begin
         failures++; $display("FAIL reen_first got s=%h v=%b c=%b exp s=000 v=1 c=1", sample, sample_valid, cycle_start); end
      pulse_tick(1);
      checks++; if (sample !== 12'h100 || cycle_start !== 1'b0) begin
         failures++; $display("FAIL reen_second got s=%h c=%b exp s=100 c=0", sample, cycle_start); end
   endtask

   task automatic test_back_to_back();
      load_cfg(2'd0, 16'h1000, 12'h000, 12'h000);
      tick = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (sample !== 12'(i << 8) || sample_valid !== 1'b1 || cycle_start !== (i == 0)) begin
            failures++; $display("FAIL b2b[%0d] got s=%h v=%b c=%b exp s=%h v=1 c=%b", i, sample, sample_valid, cycle_start, 12'(i << 8), (i == 0)); end
      end
      tick = 1'b0;
      step();
      checks++; if (sample_valid !== 1'b0 || sample !== 12'h300) begin
         failures++; $display("FAIL b2b_end got s=%h v=%b exp s=300 v=0", sample, sample_valid); end
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; enable = 1'b0;
      wave_sel = '0; freq_word = '0; duty = '0; dc_level = '0;
      #1;
      test_reset();
      test_fw_zero();
      test_sawtooth();
      test_triangle();
      test_square();
      test_config_wrap();
      test_disable();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/wave_sample_gen.md
Name: wave_sample_gen

Overview:
Per-channel waveform sample engine that consumes the one-cycle sample-rate strobe from the clock divider (2 MHz tick from the 100 MHz system clock). On each tick it advances a phase accumulator and emits one DAC code for sawtooth, triangle, square or DC. One instance per output channel; sine is produced by a separate LUT stage fed from the same tick.

Parameters:
PHASE_W, 16, phase accumulator width; must be >= DATA_W+1
DATA_W, 12, output sample / DAC code width

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous active-high reset
tick  in  1  sample strobe from clock divider; every cycle it is high counts as one tick
enable  in  1  channel run; low holds the channel idle
wave_sel  in  2  0 = sawtooth, 1 = triangle, 2 = square, 3 = DC
freq_word  in  PHASE_W  phase increment per tick
duty  in  DATA_W  square threshold; high while phase top bits < duty
dc_level  in  DATA_W  DC output code
sample  out  DATA_W  current DAC code (registered)
sample_valid  out  1  one-cycle pulse when sample updates
cycle_start  out  1  one-cycle pulse coincident with sample_valid on the first sample of a period

Behaviour:
- Reset (rst=1, synchronous, dominates all other inputs): phase=0, sample=0, sample_valid=0, cycle_start=0, shadow config=0 (sawtooth, fw=0, duty=0, dc=0), first_flag=1.
- Shadow config: wave_sel, freq_word, duty and dc_level are captured into shadow registers. All waveform arithmetic uses only the shadow registers.
- enable=0:
  - shadows reload from the live inputs every cycle
  - phase=0, first_flag=1
  - sample driven to 0 on the next cycle
  - sample_valid and cycle_start stay 0; tick is ignored
- enable=1 and tick=1, all effects registered on the next edge (latency 1 clk):
  - sample <= f(phase), computed from the pre-increment phase
  - phase <= (phase + fw_shadow) mod 2^PHASE_W
  - sample_valid=1
  - cycle_start = first_flag; first_flag is then cleared
- Wrap: the addition produces a carry out. On that tick:
  - shadows reload from the live inputs
  - first_flag=1
  - the next sample therefore uses the new config and carries cycle_start.
- Mid-period input changes have no effect until the wrap. This makes config changes glitch-free.
- enable=1, tick=0: all state held; sample_valid=0, cycle_start=0.
- Waveform function. Let p = phase[PHASE_W-1 -: DATA_W], p2 = phase[PHASE_W-2 -: DATA_W], m = phase[PHASE_W-1].
  - sawtooth: p
  - triangle: m ? ~p2 : p2
  - square: (p < duty_sh) ? all-ones : 0. duty=0 gives constant 0.
  - DC: dc_sh
- fw_shadow=0: phase frozen, no wrap, ticks still produce sample_valid. cycle_start fires only on the first tick after enable or reset.
- enable deasserted mid-period: idle on the next cycle. On re-enable, restart from phase 0 with cycle_start on the first sample.
- tick held high for N cycles gives N samples.
- Reset mid-operation: outputs return to reset values on the next edge, regardless of tick or enable.

Test Plan:
1. Reset: run sawtooth, assert rst 3 clk during tick -> next cycle sample=0, sample_valid=0, cycle_start=0; first sample after release with enable=1 is 0x000 with cycle_start=1.
2. Sawtooth, fw=0x1000, tick every 51 clk -> samples 0x000, 0x100, ..., 0xF00, 0x000; cycle_start on samples 1 and 17; each sample_valid lands 1 clk after its tick.
3. Triangle, fw=0x2000 -> 0x000, 0x400, 0x800, 0xC00, 0xFFF, 0xBFF, 0x7FF, 0x3FF, repeating.
4. Square, fw=0x4000, duty=0x800 -> 0xFFF, 0xFFF, 0x000, 0x000 repeating; duty=0 -> all 0x000.
5. Sawtooth fw=0x1000; at phase 0x8000 set wave_sel=3, dc_level=0x5A5 -> 0x800 through 0xF00 continue as sawtooth; next sample 0x5A5 with cycle_start=1, then constant 0x5A5.
6. enable=0 with ticks -> no sample_valid, sample=0. rst=1 and tick=1 together -> reset wins, phase=0. fw=0 -> repeated 0x000 samples, single cycle_start.
